// File: rtl/flow_gen_pkg.sv
// flow_gen_pkg: shared definitions for the flow_gen test-pattern source.
//   - register map addresses and reset values
//   - CTRL field positions
//   - pixel pattern and FSM state enums
//   - LFSR tap mask and the seed used when SEED is programmed as 0
package flow_gen_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_WIDTH  = 3'd1;
    localparam logic [2:0] ADDR_HEIGHT = 3'd2;
    localparam logic [2:0] ADDR_GAP    = 3'd3;
    localparam logic [2:0] ADDR_SEED   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_THROTTLE_BIT = 1;

    localparam logic [15:0] RST_WIDTH  = 16'd16;
    localparam logic [15:0] RST_HEIGHT = 16'd4;
    localparam logic [15:0] RST_GAP    = 16'd8;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'b00,
        PAT_CONST   = 2'b01,
        PAT_LFSR    = 2'b10,
        PAT_RAMP    = 2'b11
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the polynomial
    // terms map onto state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Geometry and gap values of 0 behave as 1.
    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == '0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/flow_gen_lfsr.sv
// flow_gen_lfsr: 16-bit Fibonacci LFSR with synchronous load and step enable.
//   clk, reset_n : clock, synchronous active-low reset
//   load_i       : load seed_i (0xACE1 substituted for a zero seed)
//   seed_i       : seed value
//   en_i         : advance one step (load has priority)
//   value_o      : current LFSR state
module flow_gen_lfsr
    import flow_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        en_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = ^(lfsr_q & LFSR_TAPS);
        lfsr_d   = lfsr_q;
        if (load_i) begin
            // A zero seed would lock the register at zero forever.
            lfsr_d = (seed_i == '0) ? LFSR_DEFAULT_SEED : seed_i;
        end else if (en_i) begin
            lfsr_d = {feedback, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/flow_gen.sv
// flow_gen: register-programmed image flow source (out_fv / out_dv / out_data).
//   clk, reset_n        : clock, synchronous active-low reset
//   addr_rel_i, wr_i,
//   datawr_i, rd_i      : slave register port (CTRL, WIDTH, HEIGHT, GAP, SEED, STATUS)
//   datard_o            : registered read data, valid the cycle after rd_i
//   out_fv, out_dv,
//   out_data            : registered flow outputs; data is 0 outside dv cycles
// Geometry, pattern, throttle and seed are shadowed at frame start, so register
// writes during a frame only affect the next one. Flow outputs are registered
// from the FSM state, which puts out_fv two edges after the ENABLE write.
module flow_gen
    import flow_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            addr_rel_i,
    input  logic                  wr_i,
    input  logic [31:0]           datawr_i,
    input  logic                  rd_i,
    output logic [31:0]           datard_o,
    output logic                  out_fv,
    output logic                  out_dv,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Programmable registers
    logic [3:0]  ctrl_q,   ctrl_d;
    logic [15:0] width_q,  width_d;
    logic [15:0] height_q, height_d;
    logic [15:0] gap_q,    gap_d;
    logic [15:0] seed_q,   seed_d;
    logic [31:0] datard_q, datard_d;

    // Frame-start shadows
    logic [15:0] sh_width_q,    sh_width_d;
    logic [15:0] sh_height_q,   sh_height_d;
    logic [15:0] sh_seed_q,     sh_seed_d;
    pattern_e    sh_pattern_q,  sh_pattern_d;
    logic        sh_throttle_q, sh_throttle_d;

    // FSM and counters
    state_e                state_q,     state_d;
    logic [15:0]           x_q,         x_d;
    logic [15:0]           y_q,         y_d;
    logic [DATA_WIDTH-1:0] pix_q,       pix_d;
    logic [15:0]           gap_cnt_q,   gap_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    // Registered flow outputs
    logic                  out_fv_q,   out_fv_d;
    logic                  out_dv_q,   out_dv_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic        frame_start;
    logic        pix_valid;
    logic        last_pixel;
    logic        busy;
    logic [15:0] lfsr_value;
    logic        unused_wr_hi;

    assign unused_wr_hi = ^datawr_i[31:16];
    assign busy         = (state_q == FRAME);

    // Zero-extend or truncate a 16-bit quantity to the flow data width.
    function automatic logic [DATA_WIDTH-1:0] fit16(input logic [15:0] v);
        logic [DATA_WIDTH+15:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, v};
        return ext[DATA_WIDTH-1:0];
    endfunction

    flow_gen_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (frame_start),
        .seed_i  (seed_q),
        .en_i    (busy),
        .value_o (lfsr_value)
    );

    // Register file: reads sample the pre-write values, so a same-cycle
    // write and read of one address returns the old contents.
    always_comb begin
        ctrl_d   = ctrl_q;
        width_d  = width_q;
        height_d = height_q;
        gap_d    = gap_q;
        seed_d   = seed_q;
        datard_d = datard_q;

        if (wr_i) begin
            case (addr_rel_i)
                ADDR_CTRL:   ctrl_d   = datawr_i[3:0];
                ADDR_WIDTH:  width_d  = datawr_i[15:0];
                ADDR_HEIGHT: height_d = datawr_i[15:0];
                ADDR_GAP:    gap_d    = datawr_i[15:0];
                ADDR_SEED:   seed_d   = datawr_i[15:0];
                default:     ;
            endcase
        end

        if (rd_i) begin
            case (addr_rel_i)
                ADDR_CTRL:   datard_d = {28'd0, ctrl_q};
                ADDR_WIDTH:  datard_d = {16'd0, width_q};
                ADDR_HEIGHT: datard_d = {16'd0, height_q};
                ADDR_GAP:    datard_d = {16'd0, gap_q};
                ADDR_SEED:   datard_d = {16'd0, seed_q};
                ADDR_STATUS: datard_d = {15'd0, busy, frame_cnt_q};
                default:     datard_d = '0;
            endcase
        end
    end

    // FSM next state, pixel counters and shadow capture.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_d         = pix_q;
        gap_cnt_d     = gap_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        sh_width_d    = sh_width_q;
        sh_height_d   = sh_height_q;
        sh_seed_d     = sh_seed_q;
        sh_pattern_d  = sh_pattern_q;
        sh_throttle_d = sh_throttle_q;
        frame_start   = 1'b0;
        pix_valid     = 1'b0;
        last_pixel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_q[CTRL_ENABLE_BIT]) begin
                    state_d     = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                pix_valid = sh_throttle_q ? lfsr_value[0] : 1'b1;
                if (pix_valid) begin
                    last_pixel = (x_q == sh_width_q - 16'd1) &&
                                 (y_q == sh_height_q - 16'd1);
                    pix_d = pix_q + DATA_WIDTH'(1);
                    if (x_q == sh_width_q - 16'd1) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    if (last_pixel) begin
                        state_d     = GAP;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // Counts down to 0, giving max(GAP,1) cycles in GAP.
                        gap_cnt_d   = at_least_one(gap_q) - 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (ctrl_q[CTRL_ENABLE_BIT]) begin
                        state_d     = FRAME;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            x_d           = '0;
            y_d           = '0;
            pix_d         = '0;
            sh_width_d    = at_least_one(width_q);
            sh_height_d   = at_least_one(height_q);
            sh_seed_d     = seed_q;
            sh_pattern_d  = pattern_e'(ctrl_q[3:2]);
            sh_throttle_d = ctrl_q[CTRL_THROTTLE_BIT];
        end
    end

    // Output stage: reflects the FRAME cycle just evaluated.
    always_comb begin
        out_fv_d   = busy;
        out_dv_d   = pix_valid;
        out_data_d = '0;
        if (pix_valid) begin
            case (sh_pattern_q)
                PAT_COUNTER: out_data_d = pix_q;
                PAT_CONST:   out_data_d = fit16(sh_seed_q);
                PAT_LFSR:    out_data_d = fit16(lfsr_value);
                PAT_RAMP:    out_data_d = fit16(x_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            width_q       <= RST_WIDTH;
            height_q      <= RST_HEIGHT;
            gap_q         <= RST_GAP;
            seed_q        <= '0;
            datard_q      <= '0;
            sh_width_q    <= 16'd1;
            sh_height_q   <= 16'd1;
            sh_seed_q     <= '0;
            sh_pattern_q  <= PAT_COUNTER;
            sh_throttle_q <= 1'b0;
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            pix_q         <= '0;
            gap_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            out_fv_q      <= 1'b0;
            out_dv_q      <= 1'b0;
            out_data_q    <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            width_q       <= width_d;
            height_q      <= height_d;
            gap_q         <= gap_d;
            seed_q        <= seed_d;
            datard_q      <= datard_d;
            sh_width_q    <= sh_width_d;
            sh_height_q   <= sh_height_d;
            sh_seed_q     <= sh_seed_d;
            sh_pattern_q  <= sh_pattern_d;
            sh_throttle_q <= sh_throttle_d;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_q         <= pix_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            out_fv_q      <= out_fv_d;
            out_dv_q      <= out_dv_d;
            out_data_q    <= out_data_d;
        end
    end

    assign datard_o = datard_q;
    assign out_fv   = out_fv_q;
    assign out_dv   = out_dv_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_flow_gen.sv
// tb_flow_gen: self-checking bench for flow_gen. A frame-level model builds the
// expected per-cycle output stream of each frame when it starts and checks the
// DUT every cycle; directed tests add literal expectations on top.
module tb_flow_gen;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    addr_rel_i = '0;
    logic          wr_i = 1'b0;
    logic [31:0]   datawr_i = '0;
    logic          rd_i = 1'b0;
    logic [31:0]   datard_o;
    logic          out_fv;
    logic          out_dv;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    flow_gen #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_rel_i (addr_rel_i),
        .wr_i       (wr_i),
        .datawr_i   (datawr_i),
        .rd_i       (rd_i),
        .datard_o   (datard_o),
        .out_fv     (out_fv),
        .out_dv     (out_dv),
        .out_data   (out_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        dv;
        logic [15:0] data;
        logic        last;
    } ent_t;

    ent_t        q_exp[$];
    logic [3:0]  m_ctrl;
    logic [15:0] m_w, m_h, m_g, m_seed, m_frames;
    int          m_gap_left;
    logic        e_fv = 1'b0, e_dv = 1'b0;
    logic [15:0] e_data = '0;
    logic [31:0] e_rd = '0;
    logic        rd_pending = 1'b0;
    logic        model_ok = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] b;
        b = 16'((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1);
        return (s >> 1) | (b << 15);
    endfunction

    // Whole frame, one entry per cycle of fv high.
    task automatic gen_frame();
        int          w, h, total, pix, guard;
        logic [15:0] l;
        ent_t        e;
        w = (m_w == 0) ? 1 : int'(m_w);
        h = (m_h == 0) ? 1 : int'(m_h);
        total = w * h;
        l = (m_seed == 0) ? 16'hACE1 : m_seed;
        pix = 0;
        guard = 0;
        while (pix < total && guard < 50000) begin
            e.dv = m_ctrl[1] ? l[0] : 1'b1;
            e.data = '0;
            e.last = 1'b0;
            if (e.dv) begin
                case (m_ctrl[3:2])
                    2'd0: e.data = 16'(pix);
                    2'd1: e.data = m_seed;
                    2'd2: e.data = l;
                    default: e.data = 16'(pix % w);
                endcase
                e.last = (pix == total - 1);
                pix++;
            end
            q_exp.push_back(e);
            l = lfsr_next(l);
            guard++;
        end
    endtask

    task automatic model_step();
        ent_t e;
        logic popped;
        if (!reset_n) begin
            q_exp.delete();
            m_ctrl = '0; m_w = 16; m_h = 4; m_g = 8; m_seed = 0; m_frames = 0;
            m_gap_left = 0;
            e_fv = 0; e_dv = 0; e_data = 0;
            rd_pending = 1'b1; e_rd = '0;
            model_ok = 1'b1;
            return;
        end
        rd_pending = rd_i;
        if (rd_i) begin
            case (addr_rel_i)
                3'd0: e_rd = {28'd0, m_ctrl};
                3'd1: e_rd = {16'd0, m_w};
                3'd2: e_rd = {16'd0, m_h};
                3'd3: e_rd = {16'd0, m_g};
                3'd4: e_rd = {16'd0, m_seed};
                3'd5: e_rd = {15'd0, (q_exp.size() != 0), m_frames};
                default: e_rd = '0;
            endcase
        end
        popped = 1'b0;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            e_fv = 1; e_dv = e.dv; e_data = e.data;
            popped = 1'b1;
            if (e.last) begin
                m_frames++;
                m_gap_left = (m_g == 0) ? 1 : int'(m_g);
            end
        end else begin
            e_fv = 0; e_dv = 0; e_data = 0;
        end
        if (!popped) begin
            if (m_gap_left > 0) begin
                m_gap_left--;
                if (m_gap_left == 0 && m_ctrl[0]) gen_frame();
            end else if (m_ctrl[0]) begin
                gen_frame();
            end
        end
        if (wr_i) begin
            case (addr_rel_i)
                3'd0: m_ctrl = datawr_i[3:0];
                3'd1: m_w    = datawr_i[15:0];
                3'd2: m_h    = datawr_i[15:0];
                3'd3: m_g    = datawr_i[15:0];
                3'd4: m_seed = datawr_i[15:0];
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare + recorder ----------------
    logic [15:0] cap[$];
    int          hi_runs[$], lo_runs[$], dv_runs[$], lastdv_runs[$];
    int          hi_len = 0, lo_len = 0, run_dv = 0, dv_outside = 0;
    logic        last_dv = 1'b0, prev_fv = 1'b0, seen_hi = 1'b0;

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("fv", {31'd0, out_fv}, {31'd0, e_fv});
            check("dv", {31'd0, out_dv}, {31'd0, e_dv});
            check("data", {16'd0, out_data}, {16'd0, e_data});
            if (rd_pending) check("datard", datard_o, e_rd);
        end
        if (out_dv === 1'b1 && out_fv !== 1'b1) dv_outside++;
        if (out_dv === 1'b1) cap.push_back(out_data);
        if (out_fv === 1'b1) begin
            if (!prev_fv && seen_hi) lo_runs.push_back(lo_len);
            hi_len++;
            if (out_dv === 1'b1) run_dv++;
            last_dv = (out_dv === 1'b1);
            prev_fv = 1'b1;
        end else begin
            if (prev_fv) begin
                hi_runs.push_back(hi_len);
                dv_runs.push_back(run_dv);
                lastdv_runs.push_back(int'(last_dv));
                hi_len = 0; run_dv = 0; lo_len = 0; seen_hi = 1'b1;
            end
            lo_len++;
            prev_fv = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_rec();
        cap.delete(); hi_runs.delete(); lo_runs.delete();
        dv_runs.delete(); lastdv_runs.delete();
        hi_len = 0; lo_len = 0; run_dv = 0; seen_hi = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
        @(negedge clk);
        wr_i = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        addr_rel_i = a; rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        v = datard_o;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        reg_read(a, v);
        check(name, v, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cap(input int n, input int budget, input string name);
        int k = 0;
        while (cap.size() < n && k < budget) begin @(negedge clk); k++; end
        check(name, (cap.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_hi_runs(input int n, input int budget, input string name);
        int k = 0;
        while (hi_runs.size() < n && k < budget) begin @(negedge clk); k++; end
        check(name, (hi_runs.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_quiet(input string name);
        int low = 0, k = 0;
        while (low < 20 && k < 3000) begin
            @(negedge clk); k++;
            if (out_fv === 1'b0) low++; else low = 0;
        end
        check(name, (low >= 20) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_cap(input string name, input int idx, input logic [15:0] exp);
        check(name, (idx < cap.size()) ? {16'd0, cap[idx]} : 32'hDEAD_0000, {16'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] v;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state and register map
        check("rst_fv", {31'd0, out_fv}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        read_check("rst_width", 3'd1, 32'd16);
        read_check("rst_height", 3'd2, 32'd4);
        read_check("rst_gap", 3'd3, 32'd8);
        read_check("rst_ctrl", 3'd0, 32'd0);
        read_check("rst_status", 3'd5, 32'd0);
        read_check("rd_addr6", 3'd6, 32'd0);
        reg_write(3'd5, 32'hFFFF_FFFF);
        read_check("status_ro", 3'd5, 32'd0);
        // Same-cycle write and read returns the old value
        @(negedge clk);
        addr_rel_i = 3'd1; datawr_i = 32'h77; wr_i = 1'b1; rd_i = 1'b1;
        @(negedge clk);
        wr_i = 1'b0; rd_i = 1'b0;
        check("wr_rd_old", datard_o, 32'd16);
        read_check("wr_rd_new", 3'd1, 32'h77);

        // Basic counter frames: 4x2, gap 3
        reg_write(3'd1, 32'd4);
        reg_write(3'd2, 32'd2);
        reg_write(3'd3, 32'd3);
        clear_rec();
        reg_write(3'd0, 32'h1);
        wait_hi_runs(2, 300, "basic_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("basic_quiet");
        for (int i = 0; i < 16; i++) check_cap("basic_data", i, 16'(i % 8));
        check("basic_fv_hi0", 32'(hi_runs.size() > 0 ? hi_runs[0] : -1), 32'd8);
        check("basic_fv_hi1", 32'(hi_runs.size() > 1 ? hi_runs[1] : -1), 32'd8);
        check("basic_fv_lo", 32'(lo_runs.size() > 0 ? lo_runs[0] : -1), 32'd3);

        // Ramp: 3x2
        reg_write(3'd1, 32'd3);
        clear_rec();
        reg_write(3'd0, 32'hD);
        wait_hi_runs(1, 200, "ramp_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("ramp_quiet");
        for (int i = 0; i < 6; i++) check_cap("ramp_data", i, 16'(i % 3));

        // LFSR pattern from seed 1
        reg_write(3'd1, 32'd4);
        reg_write(3'd2, 32'd1);
        reg_write(3'd4, 32'd1);
        clear_rec();
        reg_write(3'd0, 32'h9);
        wait_hi_runs(1, 200, "lfsr_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("lfsr_quiet");
        check_cap("lfsr_d0", 0, 16'h0001);
        check_cap("lfsr_d1", 1, 16'h8000);
        check_cap("lfsr_d2", 2, 16'h4000);
        check_cap("lfsr_d3", 3, 16'h2000);

        // Throttled frame: 5x1, seed 1
        reg_write(3'd1, 32'd5);
        clear_rec();
        reg_write(3'd0, 32'h3);
        wait_hi_runs(1, 1000, "thr_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("thr_quiet");
        check("thr_dv_count", 32'(dv_runs.size() > 0 ? dv_runs[0] : -1), 32'd5);
        check("thr_last_dv", 32'(lastdv_runs.size() > 0 ? lastdv_runs[0] : -1), 32'd1);
        for (int i = 0; i < 5; i++) check_cap("thr_data", i, 16'(i));

        // Disable mid-frame: 8x1, CTRL cleared at pixel 3
        do_reset();
        reg_write(3'd1, 32'd8);
        reg_write(3'd2, 32'd1);
        reg_write(3'd3, 32'd3);
        clear_rec();
        reg_write(3'd0, 32'h1);
        wait_cap(3, 100, "dis_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("dis_quiet");
        check("dis_frames", 32'(hi_runs.size()), 32'd1);
        check("dis_fv_hi", 32'(hi_runs.size() > 0 ? hi_runs[0] : -1), 32'd8);
        check("dis_dv_count", 32'(dv_runs.size() > 0 ? dv_runs[0] : -1), 32'd8);
        read_check("dis_status", 3'd5, 32'h0000_0001);

        // Reset mid-frame at pixel 2
        clear_rec();
        reg_write(3'd0, 32'h1);
        wait_cap(2, 100, "rstmid_wait");
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_fv", {31'd0, out_fv}, 32'd0);
        check("rstmid_dv", {31'd0, out_dv}, 32'd0);
        check("rstmid_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        read_check("rstmid_width", 3'd1, 32'd16);
        read_check("rstmid_height", 3'd2, 32'd4);
        read_check("rstmid_gap", 3'd3, 32'd8);
        read_check("rstmid_status", 3'd5, 32'd0);

        // Degenerate geometry: 0x0, gap 0, constant 0x1234
        reg_write(3'd1, 32'd0);
        reg_write(3'd2, 32'd0);
        reg_write(3'd3, 32'd0);
        reg_write(3'd4, 32'h1234);
        clear_rec();
        reg_write(3'd0, 32'h5);
        wait_hi_runs(4, 100, "deg_wait");
        reg_write(3'd0, 32'h0);
        wait_quiet("deg_quiet");
        for (int i = 0; i < 4; i++) begin
            check("deg_fv_hi", 32'(hi_runs.size() > i ? hi_runs[i] : -1), 32'd1);
            check_cap("deg_data", i, 16'h1234);
        end
        for (int i = 0; i < 3; i++)
            check("deg_fv_lo", 32'(lo_runs.size() > i ? lo_runs[i] : -1), 32'd1);

        check("dv_outside_fv", 32'(dv_outside), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flow_gen.md
# flow_gen

Flow source that synthesises GPStudio-style image frames (`out_fv` / `out_dv` / `out_data`) from register-programmed geometry, pattern and throttling. It is the transmitting end of the flow interface consumed by processing blocks such as normhw. It replaces file-driven stimulus on the bench and serves as an on-chip test-pattern source ahead of any process block. Configuration goes through the standard slave register port.

## Interface

Parameters:

- `DATA_WIDTH`, default 16: flow data width.

Ports:

- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `addr_rel_i`, input, 3: register address.
- `wr_i`, input, 1: register write strobe.
- `datawr_i`, input, 32: write data.
- `rd_i`, input, 1: register read strobe.
- `datard_o`, output, 32: read data. Registered; valid the cycle after `rd_i`.
- `out_fv`, output, 1: frame valid.
- `out_dv`, output, 1: data valid. Only ever asserted while `out_fv` is high.
- `out_data`, output, `DATA_WIDTH`: pixel value.

## Operation

Registers (reset value in brackets):

- 0 CTRL [0]
  - bit0 ENABLE.
  - bit1 THROTTLE.
  - bits3:2 PATTERN: 00 = counter, 01 = constant, 10 = LFSR, 11 = ramp.
- 1 WIDTH[15:0] [16].
- 2 HEIGHT[15:0] [4].
- 3 GAP[15:0] [8].
- 4 SEED[15:0] [0].
- 5 STATUS, read-only:
  - bits15:0: frames completed since reset, wrapping at 0xFFFF.
  - bit16: busy, meaning the FSM is in FRAME.
- Writes to address 5 or 6–7 are ignored. Reads of 6–7 return 0.

Frame-start shadowing:

- WIDTH, HEIGHT, PATTERN, THROTTLE and SEED are latched into shadow registers at frame start.
- Writes during a frame take effect at the next frame.
- A WIDTH or HEIGHT of 0 is treated as 1.

FSM states:

- IDLE: `out_fv`=0. Go to FRAME when ENABLE=1.
- FRAME: `out_fv`=1. Pixel counters x, y start at 0.
  - Each cycle, dv = 1 if THROTTLE=0, else dv = LFSR bit0.
  - On each dv cycle, x increments. At x=W-1, x wraps to 0 and y increments.
  - The dv cycle with x=W-1, y=H-1 is the last pixel. Go to GAP, and increment the frame counter.
- GAP: `out_fv`=0. Stay max(GAP,1) cycles, then go to FRAME if ENABLE=1, else IDLE.

Clearing ENABLE mid-frame never truncates the frame. The current frame and its gap complete, then the FSM enters IDLE.

Data on dv cycles:

- Counter: pixel index y·W+x, modulo 2^DATA_WIDTH, restarting at 0 each frame.
- Constant: SEED.
- LFSR: current LFSR value.
- Ramp: x.
- Outside dv cycles, `out_data` holds 0.

LFSR:

- 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- Loaded at frame start with SEED, or with 0xACE1 if SEED=0.
- Advances every FRAME cycle.
- When DATA_WIDTH≠16, data is zero-extended or truncated.

## Timing

- All flow outputs are registered.
  - Reset values: `out_fv`/`out_dv`/`out_data`/`datard_o` = 0, FSM = IDLE, counters = 0.
  - Reset is honoured mid-frame: all outputs are 0 after the reset edge, with no partial-frame completion.
- A write to CTRL.ENABLE at edge n gives `out_fv`=1 at edge n+2.
- `out_fv` falls on the edge after the last dv cycle.
- The low time of `out_fv` between frames is exactly max(GAP,1) cycles.
- With THROTTLE=0, a frame is exactly W·H cycles of fv high, all with dv.
- A simultaneous `wr_i` and `rd_i` on the same address returns the old value.

## Structure

- Package `flow_gen_pkg` holds:
  - register address constants;
  - pattern encoding enum;
  - FSM state enum (IDLE, FRAME, GAP);
  - LFSR tap mask and default seed 0xACE1.
- Sub-module `flow_gen_lfsr`: 16-bit LFSR with load and enable. Used once.
- The top level holds the register file, shadows, FSM, counters and the data mux.

## Test plan

- **Basic counter frames.** Reset; WIDTH=4, HEIGHT=2, GAP=3; CTRL=0x1.
  - Expect 8 consecutive dv cycles with data 0..7 and fv high exactly 8 cycles.
  - Expect fv low exactly 3 cycles, then an identical frame.
- **Ramp pattern.** WIDTH=3, HEIGHT=2, CTRL=0xD.
  - Expect data 0,1,2,0,1,2.
- **Throttled frame.** WIDTH=5, HEIGHT=1, CTRL=0x3, SEED=0x0001.
  - Expect exactly 5 dv pulses, never outside fv.
  - Expect fv to drop the edge after the 5th dv.
- **Disable mid-frame.** Write CTRL=0 at pixel 3 of an 8-pixel frame.
  - Expect all 8 pixels, then the gap, then IDLE.
  - Expect STATUS = 0x00000001 (count 1, busy 0).
- **Reset mid-frame.** Pull `reset_n` low at pixel 2.
  - Expect fv/dv/data = 0 after the edge.
  - Expect register reads to return defaults: WIDTH=16, HEIGHT=4, GAP=8.
- **Degenerate geometry.** WIDTH=0, HEIGHT=0, GAP=0, CTRL=0x5 (constant), SEED=0x1234.
  - Expect 1-pixel frames of value 0x1234, fv high 1 cycle and low 1 cycle, repeating.
